// File: rtl/inventory_pkg.sv
// Shared types for the inventory tracker.
package inventory_pkg;

  typedef enum logic {
    ITEM_EMPTY = 1'b0,
    ITEM_HELD  = 1'b1
  } item_state_t;

endpackage

// File: rtl/inventory_slot.sv
// One inventory item: sticky (found once, held until clear/reset) or
// consumable (saturating unit count, held while count is non-zero).
module inventory_slot
  import inventory_pkg::*;
#(
  parameter bit          CONSUMABLE = 1'b0,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_found,
  input  logic             i_use,
  input  logic             i_clear,
  output logic             o_have,
  output logic [CNT_W-1:0] o_count,
  output logic             o_acquired,
  output logic             o_use_denied
);

  item_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acquired;
  logic             r_use_denied;

  item_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_acquired_nxt;
  logic             w_use_denied_nxt;

  // State register with asynchronous reset; pulses are registered too.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ITEM_EMPTY;
      r_cnt        <= '0;
      r_acquired   <= 1'b0;
      r_use_denied <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_acquired   <= w_acquired_nxt;
      r_use_denied <= w_use_denied_nxt;
    end
  end

  // Next-state logic: clear wins; otherwise sticky or consumable update.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_use_denied_nxt = 1'b0;
    if (i_clear) begin
      w_state_nxt = ITEM_EMPTY;
      w_cnt_nxt   = '0;
    end else if (CONSUMABLE) begin
      // found and use together cancel out, so only the lone cases act
      if (i_found && !i_use) begin
        if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if (i_use && !i_found) begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        else             w_use_denied_nxt = 1'b1;
      end
      w_state_nxt = (w_cnt_nxt != '0) ? ITEM_HELD : ITEM_EMPTY;
    end else begin
      if (i_found) w_state_nxt = ITEM_HELD;
      w_cnt_nxt = (w_state_nxt == ITEM_HELD) ? CNT_W'(1) : '0;
    end
    w_acquired_nxt = (r_state == ITEM_EMPTY) && (w_state_nxt == ITEM_HELD);
  end

  // Output decode from registered state.
  always_comb begin
    o_have       = (r_state == ITEM_HELD);
    o_count      = r_cnt;
    o_acquired   = r_acquired;
    o_use_denied = r_use_denied;
  end

endmodule

// File: rtl/inventory_fsm.sv
// Inventory tracker: NUM_ITEMS independent slots plus an all-held flag.
module inventory_fsm
  import inventory_pkg::*;
#(
  parameter int unsigned          NUM_ITEMS       = 4,
  parameter int unsigned          CNT_W           = 3,
  parameter logic [NUM_ITEMS-1:0] CONSUMABLE_MASK = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_ITEMS-1:0]       i_found,
  input  logic [NUM_ITEMS-1:0]       i_use,
  input  logic                       i_clear,
  output logic [NUM_ITEMS-1:0]       o_have,
  output logic [NUM_ITEMS*CNT_W-1:0] o_count,
  output logic                       o_all_found,
  output logic [NUM_ITEMS-1:0]       o_acquired,
  output logic [NUM_ITEMS-1:0]       o_use_denied
);

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_slot
    inventory_slot #(
      .CONSUMABLE (CONSUMABLE_MASK[g]),
      .CNT_W      (CNT_W)
    ) u_slot (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_found      (i_found[g]),
      .i_use        (i_use[g]),
      .i_clear      (i_clear),
      .o_have       (o_have[g]),
      .o_count      (o_count[g*CNT_W +: CNT_W]),
      .o_acquired   (o_acquired[g]),
      .o_use_denied (o_use_denied[g])
    );
  end

  // All-held flag is purely combinational on the registered have bits.
  always_comb begin
    o_all_found = &o_have;
  end

endmodule

// File: tb/tb_inventory_fsm.sv
// Directed bench: NUM_ITEMS=4, CNT_W=3, items 2 and 3 consumable.
module tb_inventory_fsm;

  logic        clk;
  logic        reset;
  logic [3:0]  found;
  logic [3:0]  use_r;
  logic        clear;
  logic [3:0]  have;
  logic [11:0] count;
  logic        all_found;
  logic [3:0]  acquired;
  logic [3:0]  use_denied;

  int n_checks = 0;
  int n_pass   = 0;

  inventory_fsm #(
    .NUM_ITEMS       (4),
    .CNT_W           (3),
    .CONSUMABLE_MASK (4'b1100)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_found      (found),
    .i_use        (use_r),
    .i_clear      (clear),
    .o_have       (have),
    .o_count      (count),
    .o_all_found  (all_found),
    .o_acquired   (acquired),
    .o_use_denied (use_denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pack(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  initial begin
    reset = 1'b1; found = '0; use_r = '0; clear = 1'b0;
    #12;
    chk("rst_have",  32'(have),       32'h0);
    chk("rst_count", 32'(count),      32'h0);
    chk("rst_all",   32'(all_found),  32'h0);
    chk("rst_acq",   32'(acquired),   32'h0);
    chk("rst_den",   32'(use_denied), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // sticky item 0
    found = 4'b0001;
    step();
    chk("stk_have",  32'(have),     32'h1);
    chk("stk_acq",   32'(acquired), 32'h1);
    chk("stk_count", 32'(count),    32'(pack(0, 0, 0, 1)));
    found = '0; use_r = 4'b0001;
    step();
    chk("stk_use_have", 32'(have),       32'h1);
    chk("stk_use_acq",  32'(acquired),   32'h0);
    chk("stk_use_den",  32'(use_denied), 32'h0);
    chk("stk_use_cnt",  32'(count),      32'(pack(0, 0, 0, 1)));

    // underflow on consumable item 3
    use_r = 4'b1000;
    step();
    chk("uf_den",   32'(use_denied), 32'h8);
    chk("uf_count", 32'(count),      32'(pack(0, 0, 0, 1)));
    chk("uf_have",  32'(have),       32'h1);
    use_r = '0;
    step();
    chk("uf_den_clr", 32'(use_denied), 32'h0);

    // simultaneous found+use at count 0 on item 2
    found = 4'b0100; use_r = 4'b0100;
    step();
    chk("sim_count", 32'(count),      32'(pack(0, 0, 0, 1)));
    chk("sim_den",   32'(use_denied), 32'h0);
    chk("sim_acq",   32'(acquired),   32'h0);
    chk("sim_have",  32'(have),       32'h1);
    use_r = '0;

    // saturation on item 2: 9 consecutive finds
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("sat_count", 32'(count),    32'(pack(0, (k > 7) ? 7 : k, 0, 1)));
      chk("sat_acq",   32'(acquired), (k == 1) ? 32'h4 : 32'h0);
    end
    found = '0; use_r = 4'b0100;
    step();
    chk("dec_count", 32'(count), 32'(pack(0, 6, 0, 1)));
    chk("dec_have",  32'(have),  32'h5);
    use_r = '0;

    // item 3: gain one unit, then spend it
    found = 4'b1000;
    step();
    chk("i3_count", 32'(count),    32'(pack(1, 6, 0, 1)));
    chk("i3_acq",   32'(acquired), 32'h8);
    found = '0; use_r = 4'b1000;
    step();
    chk("i3_use_count", 32'(count),      32'(pack(0, 6, 0, 1)));
    chk("i3_use_have",  32'(have),       32'h5);
    chk("i3_use_den",   32'(use_denied), 32'h0);
    use_r = '0;

    // collect the rest -> all_found
    found = 4'b1010;
    step();
    chk("all_have",  32'(have),      32'hF);
    chk("all_flag",  32'(all_found), 32'h1);
    chk("all_acq",   32'(acquired),  32'hA);
    chk("all_count", 32'(count),     32'(pack(1, 6, 1, 1)));

    // clear beats found
    found = 4'b1111; clear = 1'b1;
    step();
    chk("clr_have",  32'(have),       32'h0);
    chk("clr_all",   32'(all_found),  32'h0);
    chk("clr_acq",   32'(acquired),   32'h0);
    chk("clr_den",   32'(use_denied), 32'h0);
    chk("clr_count", 32'(count),      32'h0);
    clear = 1'b0;

    // refill then async reset mid-cycle
    step();
    chk("refill_have", 32'(have),     32'hF);
    chk("refill_acq",  32'(acquired), 32'hF);
    found = '0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_have",  32'(have),       32'h0);
    chk("arst_count", 32'(count),      32'h0);
    chk("arst_all",   32'(all_found),  32'h0);
    chk("arst_acq",   32'(acquired),   32'h0);
    chk("arst_den",   32'(use_denied), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    found = 4'b0001;
    step();
    chk("post_rst_have",  32'(have),     32'h1);
    chk("post_rst_acq",   32'(acquired), 32'h1);
    chk("post_rst_count", 32'(count),    32'(pack(0, 0, 0, 1)));
    found = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inventory_fsm.md
INVENTORY_FSM -- requirements
Module: inventory_fsm

Interface
REQ-001 The block SHALL have parameter NUM_ITEMS, default 4, giving the number of tracked items (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the per-item count width for consumable items (1..8).
REQ-003 The block SHALL have parameter CONSUMABLE_MASK, default '0, a NUM_ITEMS-bit vector where bit i=1 makes item i consumable and bit i=0 makes it sticky.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port found, input, NUM_ITEMS bits: bit i high means item i was found this cycle.
REQ-007 The block SHALL have port use, input, NUM_ITEMS bits: bit i high is a request to consume one unit of item i.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous clear of all inventory.
REQ-009 The block SHALL have port have, output, NUM_ITEMS bits: bit i high means item i is held.
REQ-010 The block SHALL have port count, output, NUM_ITEMS*CNT_W bits: packed per-item counts, with item i at bits [i*CNT_W +: CNT_W].
REQ-011 The block SHALL have port all_found, output, 1 bit: high while every item is held.
REQ-012 The block SHALL have port acquired, output, NUM_ITEMS bits: one-cycle pulse when item i goes from not-held to held.
REQ-013 The block SHALL have port use_denied, output, NUM_ITEMS bits: one-cycle pulse when a use request for a consumable item i is rejected.

Function
REQ-014 Each item SHALL hold one of two states, ITEM_EMPTY or ITEM_HELD, in a register; have[i] SHALL equal (state==ITEM_HELD).
REQ-015 Sticky item: the state SHALL go ITEM_EMPTY->ITEM_HELD on the clock edge sampling found[i]=1, then stay ITEM_HELD until reset or clear; use[i] SHALL be ignored and SHALL never cause use_denied.
REQ-016 Sticky item: the count field SHALL read 1 when held and 0 when empty.
REQ-017 Consumable item: on found only, the count SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap and no error.
REQ-018 Consumable item: on use only with count>0, the count SHALL decrement by 1; on use only with count==0, the count SHALL stay 0 and use_denied[i] SHALL pulse.
REQ-019 Consumable item: on simultaneous found and use, the count SHALL be unchanged and use_denied SHALL not pulse, including when count==0.
REQ-020 Consumable item: the state SHALL be ITEM_HELD exactly when count!=0.
REQ-021 Latency: have, count, acquired and use_denied SHALL all be registered and SHALL reflect the input sampled at edge N in the cycle after edge N.
REQ-022 acquired[i] SHALL be high for exactly the one cycle in which have[i] first reads 1 after reading 0, and SHALL be low otherwise.
REQ-023 all_found SHALL be the combinational AND of have, with no extra latency.
REQ-024 clear=1 SHALL set all items to ITEM_EMPTY with count 0 at the next edge, taking priority over found and use, and SHALL produce no acquired or use_denied pulses in that cycle.
REQ-025 Items SHALL be fully independent; activity on item i SHALL not affect item j.

Reset
REQ-026 While reset is high, every item SHALL be ITEM_EMPTY with count 0, and have, count, acquired, use_denied and all_found SHALL all be 0, taking effect immediately without waiting for clk.
REQ-027 Reset asserted mid-operation SHALL discard all held state, and the first edge after reset deassertion SHALL sample inputs normally.

Structure
REQ-028 A shared package inventory_pkg SHALL hold the item_state_t enum (ITEM_EMPTY, ITEM_HELD).
REQ-029 Per-item logic SHALL live in a sub-module inventory_slot, with a CONSUMABLE parameter and CNT_W, instantiated NUM_ITEMS times by generate.

Verification (NUM_ITEMS=4, CNT_W=3, CONSUMABLE_MASK=4'b1100)
REQ-030 Sticky: found=4'b0001 for 1 cycle -> next cycle have=4'b0001, acquired=4'b0001 for 1 cycle; then use=4'b0001 -> no change and no use_denied.
REQ-031 Saturation: found[2]=1 for 9 cycles -> count[2] steps 1..7, stays 7, and acquired[2] pulses once only.
REQ-032 Underflow: with count[3]=0, use[3]=1 -> use_denied[3] pulses once and count[3] stays 0; with count[3]=1, use[3] -> count 0 and have[3]=0.
REQ-033 Simultaneous: count[2]=0 with found[2]=use[2]=1 -> count[2] stays 0, no use_denied, no acquired.
REQ-034 All-found and clear: all four items acquired -> all_found=1; then clear=1 together with found=4'b1111 -> next cycle have=0, all_found=0, no pulses.
REQ-035 Async reset: assert reset mid-cycle with have=4'b1111 -> all outputs go to 0 before the next clk edge.
